axi_xbar: RTL and testbench

- 1-master-to-2-slave AXI4 address-decoding crossbar between the memory-side port of the IFU/LSU arbiter and the physical targets.
- Slave 0 is main memory (SRAM); slave 1 is the MMIO device bus (UART/CLINT).
- Addresses outside both windows are answered by an internal decode-error responder.
- Read and write paths are independent FSMs, each with one outstanding transaction.

---
 rtl/axi_xbar.sv | 361 ++++++++++++++++++++++++++++++++++++
 tb/tb_axi_xbar.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_xbar.sv
// 1-master / 2-slave AXI4 address-decoding crossbar.
//   Slave 0: main memory window [MEM_BASE, MEM_BASE+MEM_SIZE)
//   Slave 1: MMIO device window [DEV_BASE, DEV_BASE+DEV_SIZE)
//   Anything else is answered internally with DECERR (resp 2'b11).
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   m_ar*/m_r*          upstream read address / read data channels
//   m_aw*/m_w*/m_b*     upstream write address / write data / response channels
//   s0_*, s1_*          full AXI channel set per slave, directions mirrored
// Read and write paths are independent FSMs, each with one transaction in flight.
module axi_xbar #(
  parameter logic [31:0] MEM_BASE = 32'h8000_0000,
  parameter logic [31:0] MEM_SIZE = 32'h0800_0000,
  parameter logic [31:0] DEV_BASE = 32'ha000_0000,
  parameter logic [31:0] DEV_SIZE = 32'h0100_0000
) (
  input  logic        clk,
  input  logic        rst,
  // upstream
  input  logic        m_arvalid,
  output logic        m_arready,
  input  logic [31:0] m_araddr,
  input  logic [3:0]  m_arid,
  input  logic [7:0]  m_arlen,
  input  logic [2:0]  m_arsize,
  input  logic [1:0]  m_arburst,
  output logic        m_rvalid,
  input  logic        m_rready,
  output logic [31:0] m_rdata,
  output logic [1:0]  m_rresp,
  output logic [3:0]  m_rid,
  output logic        m_rlast,
  input  logic        m_awvalid,
  output logic        m_awready,
  input  logic [31:0] m_awaddr,
  input  logic [3:0]  m_awid,
  input  logic [7:0]  m_awlen,
  input  logic [2:0]  m_awsize,
  input  logic [1:0]  m_awburst,
  input  logic        m_wvalid,
  output logic        m_wready,
  input  logic [31:0] m_wdata,
  input  logic [3:0]  m_wstrb,
  input  logic        m_wlast,
  output logic        m_bvalid,
  input  logic        m_bready,
  output logic [1:0]  m_bresp,
  output logic [3:0]  m_bid,
  // slave 0 (memory)
  output logic        s0_arvalid,
  input  logic        s0_arready,
  output logic [31:0] s0_araddr,
  output logic [3:0]  s0_arid,
  output logic [7:0]  s0_arlen,
  output logic [2:0]  s0_arsize,
  output logic [1:0]  s0_arburst,
  input  logic        s0_rvalid,
  output logic        s0_rready,
  input  logic [31:0] s0_rdata,
  input  logic [1:0]  s0_rresp,
  input  logic [3:0]  s0_rid,
  input  logic        s0_rlast,
  output logic        s0_awvalid,
  input  logic        s0_awready,
  output logic [31:0] s0_awaddr,
  output logic [3:0]  s0_awid,
  output logic [7:0]  s0_awlen,
  output logic [2:0]  s0_awsize,
  output logic [1:0]  s0_awburst,
  output logic        s0_wvalid,
  input  logic        s0_wready,
  output logic [31:0] s0_wdata,
  output logic [3:0]  s0_wstrb,
  output logic        s0_wlast,
  input  logic        s0_bvalid,
  output logic        s0_bready,
  input  logic [1:0]  s0_bresp,
  input  logic [3:0]  s0_bid,
  // slave 1 (device bus)
  output logic        s1_arvalid,
  input  logic        s1_arready,
  output logic [31:0] s1_araddr,
  output logic [3:0]  s1_arid,
  output logic [7:0]  s1_arlen,
  output logic [2:0]  s1_arsize,
  output logic [1:0]  s1_arburst,
  input  logic        s1_rvalid,
  output logic        s1_rready,
  input  logic [31:0] s1_rdata,
  input  logic [1:0]  s1_rresp,
  input  logic [3:0]  s1_rid,
  input  logic        s1_rlast,
  output logic        s1_awvalid,
  input  logic        s1_awready,
  output logic [31:0] s1_awaddr,
  output logic [3:0]  s1_awid,
  output logic [7:0]  s1_awlen,
  output logic [2:0]  s1_awsize,
  output logic [1:0]  s1_awburst,
  output logic        s1_wvalid,
  input  logic        s1_wready,
  output logic [31:0] s1_wdata,
  output logic [3:0]  s1_wstrb,
  output logic        s1_wlast,
  input  logic        s1_bvalid,
  output logic        s1_bready,
  input  logic [1:0]  s1_bresp,
  input  logic [3:0]  s1_bid
);

  typedef enum logic [1:0] {TgtS0, TgtS1, TgtErr} tgt_e;
  typedef enum logic [1:0] {RIdle, RAddr, RData, RErr} rstate_e;
  typedef enum logic [1:0] {WIdle, WAddr, WResp} wstate_e;

  // Offset compare handles wrap-around: one unsigned subtract per window.
  function automatic tgt_e decode(input logic [31:0] addr);
    logic [31:0] off0, off1;
    off0 = addr - MEM_BASE;
    off1 = addr - DEV_BASE;
    if (off0 < MEM_SIZE) return TgtS0;
    if (off1 < DEV_SIZE) return TgtS1;
    return TgtErr;
  endfunction

  rstate_e     rstate_q, rstate_d;
  tgt_e        rsel_q, rsel_d;
  logic [3:0]  rid_q, rid_d;
  logic [7:0]  rcnt_q, rcnt_d;
  wstate_e     wstate_q, wstate_d;
  tgt_e        wsel_q, wsel_d;
  logic [3:0]  bid_q, bid_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_q  <= RIdle;
      rsel_q    <= TgtS0;
      rid_q     <= '0;
      rcnt_q    <= '0;
      wstate_q  <= WIdle;
      wsel_q    <= TgtS0;
      bid_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      rstate_q  <= rstate_d;
      rsel_q    <= rsel_d;
      rid_q     <= rid_d;
      rcnt_q    <= rcnt_d;
      wstate_q  <= wstate_d;
      wsel_q    <= wsel_d;
      bid_q     <= bid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // ---------------- read path ----------------
  logic ar_to0, ar_to1, r_to0, r_to1;
  assign ar_to0 = (rstate_q == RAddr) && (rsel_q == TgtS0);
  assign ar_to1 = (rstate_q == RAddr) && (rsel_q == TgtS1);
  assign r_to0  = (rstate_q == RData) && (rsel_q == TgtS0);
  assign r_to1  = (rstate_q == RData) && (rsel_q == TgtS1);

  assign s0_arvalid = ar_to0 & m_arvalid;
  assign s0_araddr  = ar_to0 ? m_araddr  : '0;
  assign s0_arid    = ar_to0 ? m_arid    : '0;
  assign s0_arlen   = ar_to0 ? m_arlen   : '0;
  assign s0_arsize  = ar_to0 ? m_arsize  : '0;
  assign s0_arburst = ar_to0 ? m_arburst : '0;
  assign s0_rready  = r_to0 & m_rready;
  assign s1_arvalid = ar_to1 & m_arvalid;
  assign s1_araddr  = ar_to1 ? m_araddr  : '0;
  assign s1_arid    = ar_to1 ? m_arid    : '0;
  assign s1_arlen   = ar_to1 ? m_arlen   : '0;
  assign s1_arsize  = ar_to1 ? m_arsize  : '0;
  assign s1_arburst = ar_to1 ? m_arburst : '0;
  assign s1_rready  = r_to1 & m_rready;

  always_comb begin
    m_arready = 1'b0;
    m_rvalid  = 1'b0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_rid     = '0;
    m_rlast   = 1'b0;
    unique case (rstate_q)
      RAddr: begin
        unique case (rsel_q)
          TgtS0:   m_arready = s0_arready;
          TgtS1:   m_arready = s1_arready;
          default: m_arready = 1'b1;
        endcase
      end
      RData: begin
        if (rsel_q == TgtS0) begin
          m_rvalid = s0_rvalid;
          m_rdata  = s0_rdata;
          m_rresp  = s0_rresp;
          m_rid    = s0_rid;
          m_rlast  = s0_rlast;
        end else if (rsel_q == TgtS1) begin
          m_rvalid = s1_rvalid;
          m_rdata  = s1_rdata;
          m_rresp  = s1_rresp;
          m_rid    = s1_rid;
          m_rlast  = s1_rlast;
        end
      end
      RErr: begin
        m_rvalid = 1'b1;
        m_rresp  = 2'b11;
        m_rid    = rid_q;
        m_rlast  = (rcnt_q == 8'd0);
      end
      default: ;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    rsel_d   = rsel_q;
    rid_d    = rid_q;
    rcnt_d   = rcnt_q;
    unique case (rstate_q)
      RIdle: begin
        if (m_arvalid) begin
          rsel_d   = decode(m_araddr);
          rstate_d = RAddr;
        end
      end
      RAddr: begin
        if (m_arvalid && m_arready) begin
          if (rsel_q == TgtErr) begin
            rid_d    = m_arid;
            rcnt_d   = m_arlen;
            rstate_d = RErr;
          end else begin
            rstate_d = RData;
          end
        end
      end
      RData: begin
        if (m_rvalid && m_rready && m_rlast) rstate_d = RIdle;
      end
      RErr: begin
        if (m_rready) begin
          if (rcnt_q == 8'd0) rstate_d = RIdle;
          else                rcnt_d   = rcnt_q - 8'd1;
        end
      end
      default: rstate_d = RIdle;
    endcase
  end

  // ---------------- write path ----------------
  logic aw_to0, aw_to1, w_to0, w_to1, b_to0, b_to1;
  assign aw_to0 = (wstate_q == WAddr) && (wsel_q == TgtS0) && !aw_done_q;
  assign aw_to1 = (wstate_q == WAddr) && (wsel_q == TgtS1) && !aw_done_q;
  assign w_to0  = (wstate_q == WAddr) && (wsel_q == TgtS0) && !w_done_q;
  assign w_to1  = (wstate_q == WAddr) && (wsel_q == TgtS1) && !w_done_q;
  assign b_to0  = (wstate_q == WResp) && (wsel_q == TgtS0);
  assign b_to1  = (wstate_q == WResp) && (wsel_q == TgtS1);

  assign s0_awvalid = aw_to0 & m_awvalid;
  assign s0_awaddr  = aw_to0 ? m_awaddr  : '0;
  assign s0_awid    = aw_to0 ? m_awid    : '0;
  assign s0_awlen   = aw_to0 ? m_awlen   : '0;
  assign s0_awsize  = aw_to0 ? m_awsize  : '0;
  assign s0_awburst = aw_to0 ? m_awburst : '0;
  assign s0_wvalid  = w_to0 & m_wvalid;
  assign s0_wdata   = w_to0 ? m_wdata : '0;
  assign s0_wstrb   = w_to0 ? m_wstrb : '0;
  assign s0_wlast   = w_to0 & m_wlast;
  assign s0_bready  = b_to0 & m_bready;
  assign s1_awvalid = aw_to1 & m_awvalid;
  assign s1_awaddr  = aw_to1 ? m_awaddr  : '0;
  assign s1_awid    = aw_to1 ? m_awid    : '0;
  assign s1_awlen   = aw_to1 ? m_awlen   : '0;
  assign s1_awsize  = aw_to1 ? m_awsize  : '0;
  assign s1_awburst = aw_to1 ? m_awburst : '0;
  assign s1_wvalid  = w_to1 & m_wvalid;
  assign s1_wdata   = w_to1 ? m_wdata : '0;
  assign s1_wstrb   = w_to1 ? m_wstrb : '0;
  assign s1_wlast   = w_to1 & m_wlast;
  assign s1_bready  = b_to1 & m_bready;

  always_comb begin
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
    m_bresp   = '0;
    m_bid     = '0;
    if (wstate_q == WAddr) begin
      unique case (wsel_q)
        TgtS0: begin
          m_awready = s0_awready & ~aw_done_q;
          m_wready  = s0_wready & ~w_done_q;
        end
        TgtS1: begin
          m_awready = s1_awready & ~aw_done_q;
          m_wready  = s1_wready & ~w_done_q;
        end
        default: begin
          // Decode-error sink: take AW and all W beats unconditionally.
          m_awready = ~aw_done_q;
          m_wready  = ~w_done_q;
        end
      endcase
    end else if (wstate_q == WResp) begin
      unique case (wsel_q)
        TgtS0: begin
          m_bvalid = s0_bvalid;
          m_bresp  = s0_bresp;
          m_bid    = s0_bid;
        end
        TgtS1: begin
          m_bvalid = s1_bvalid;
          m_bresp  = s1_bresp;
          m_bid    = s1_bid;
        end
        default: begin
          m_bvalid = 1'b1;
          m_bresp  = 2'b11;
          m_bid    = bid_q;
        end
      endcase
    end
  end

  always_comb begin
    wstate_d  = wstate_q;
    wsel_d    = wsel_q;
    bid_d     = bid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (wstate_q)
      WIdle: begin
        if (m_awvalid) begin
          wsel_d    = decode(m_awaddr);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          wstate_d  = WAddr;
        end
      end
      WAddr: begin
        if (m_awvalid && m_awready) begin
          aw_done_d = 1'b1;
          bid_d     = m_awid;
        end
        if (m_wvalid && m_wready && m_wlast) w_done_d = 1'b1;
        if (aw_done_q && w_done_q) wstate_d = WResp;
      end
      WResp: begin
        if (m_bvalid && m_bready) wstate_d = WIdle;
      end
      default: wstate_d = WIdle;
    endcase
  end

endmodule

// File: tb/tb_axi_xbar.sv
// Randomised scoreboard bench for axi_xbar: behavioural slaves, address-window
// reference model, and a negedge monitor that pops expected transfers.
module tb_axi_xbar;
  localparam logic [31:0] MEM_BASE = 32'h8000_0000;
  localparam logic [31:0] MEM_SIZE = 32'h0800_0000;
  localparam logic [31:0] DEV_BASE = 32'ha000_0000;
  localparam logic [31:0] DEV_SIZE = 32'h0100_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic m_arvalid = 0, m_arready, m_rvalid, m_rready = 0, m_rlast;
  logic [31:0] m_araddr = 0, m_rdata;
  logic [3:0] m_arid = 0, m_rid;
  logic [7:0] m_arlen = 0;
  logic [2:0] m_arsize = 0;
  logic [1:0] m_arburst = 0, m_rresp;
  logic m_awvalid = 0, m_awready, m_wvalid = 0, m_wready, m_wlast = 0;
  logic m_bvalid, m_bready = 0;
  logic [31:0] m_awaddr = 0, m_wdata = 0;
  logic [3:0] m_awid = 0, m_wstrb = 0, m_bid;
  logic [7:0] m_awlen = 0;
  logic [2:0] m_awsize = 0;
  logic [1:0] m_awburst = 0, m_bresp;

  // DUT-driven slave-side signals
  logic s_arvalid[2], s_rready[2], s_awvalid[2], s_wvalid[2], s_bready[2], s_wlast[2];
  logic [31:0] s_araddr[2], s_awaddr[2], s_wdata[2];
  logic [3:0] s_arid[2], s_awid[2], s_wstrb[2];
  logic [7:0] s_arlen[2], s_awlen[2];
  logic [2:0] s_arsize[2], s_awsize[2];
  logic [1:0] s_arburst[2], s_awburst[2];
  // bench-driven slave-side signals
  logic s_arready[2], s_rvalid[2], s_rlast[2], s_awready[2], s_wready[2], s_bvalid[2];
  logic [31:0] s_rdata[2];
  logic [1:0] s_rresp[2], s_bresp[2];
  logic [3:0] s_rid[2], s_bid[2];

  axi_xbar dut (
    .clk(clk), .rst(rst),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rid(m_rid), .m_rlast(m_rlast),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_bid(m_bid),
    .s0_arvalid(s_arvalid[0]), .s0_arready(s_arready[0]), .s0_araddr(s_araddr[0]),
    .s0_arid(s_arid[0]), .s0_arlen(s_arlen[0]), .s0_arsize(s_arsize[0]),
    .s0_arburst(s_arburst[0]), .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]),
    .s0_rdata(s_rdata[0]), .s0_rresp(s_rresp[0]), .s0_rid(s_rid[0]), .s0_rlast(s_rlast[0]),
    .s0_awvalid(s_awvalid[0]), .s0_awready(s_awready[0]), .s0_awaddr(s_awaddr[0]),
    .s0_awid(s_awid[0]), .s0_awlen(s_awlen[0]), .s0_awsize(s_awsize[0]),
    .s0_awburst(s_awburst[0]), .s0_wvalid(s_wvalid[0]), .s0_wready(s_wready[0]),
    .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]), .s0_wlast(s_wlast[0]),
    .s0_bvalid(s_bvalid[0]), .s0_bready(s_bready[0]), .s0_bresp(s_bresp[0]),
    .s0_bid(s_bid[0]),
    .s1_arvalid(s_arvalid[1]), .s1_arready(s_arready[1]), .s1_araddr(s_araddr[1]),
    .s1_arid(s_arid[1]), .s1_arlen(s_arlen[1]), .s1_arsize(s_arsize[1]),
    .s1_arburst(s_arburst[1]), .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]),
    .s1_rdata(s_rdata[1]), .s1_rresp(s_rresp[1]), .s1_rid(s_rid[1]), .s1_rlast(s_rlast[1]),
    .s1_awvalid(s_awvalid[1]), .s1_awready(s_awready[1]), .s1_awaddr(s_awaddr[1]),
    .s1_awid(s_awid[1]), .s1_awlen(s_awlen[1]), .s1_awsize(s_awsize[1]),
    .s1_awburst(s_awburst[1]), .s1_wvalid(s_wvalid[1]), .s1_wready(s_wready[1]),
    .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]), .s1_wlast(s_wlast[1]),
    .s1_bvalid(s_bvalid[1]), .s1_bready(s_bready[1]), .s1_bresp(s_bresp[1]),
    .s1_bid(s_bid[1])
  );

  // Read data a slave returns for a given burst start address and beat.
  function automatic logic [31:0] slv_data(input int s, input logic [31:0] a,
                                           input logic [7:0] b);
    return (a + {22'd0, b, 2'b00}) ^ ((s == 1) ? 32'h5a5a_0000 : 32'h0c0c_0000);
  endfunction

  // ---------------- behavioural slaves ----------------
  for (genvar g = 0; g < 2; g++) begin : g_slv
    logic rbusy, rv_en, ar_rnd, aw_rnd, w_rnd, awgot, wgot;
    logic [31:0] raddr;
    logic [3:0] rid_l, bid_l;
    logic [7:0] rlen, rbeat;
    assign s_arready[g] = !rbusy && ar_rnd;
    assign s_rvalid[g]  = rbusy && rv_en;
    assign s_rdata[g]   = rbusy ? slv_data(g, raddr, rbeat) : 32'd0;
    assign s_rresp[g]   = 2'b00;
    assign s_rid[g]     = rid_l;
    assign s_rlast[g]   = rbusy && (rbeat == rlen);
    assign s_awready[g] = !awgot && aw_rnd;
    assign s_wready[g]  = !wgot && w_rnd;
    assign s_bvalid[g]  = awgot && wgot;
    assign s_bresp[g]   = (g == 1) ? 2'b01 : 2'b00;
    assign s_bid[g]     = bid_l;
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        rbusy <= 0; rv_en <= 0; ar_rnd <= 0; aw_rnd <= 0; w_rnd <= 0;
        awgot <= 0; wgot <= 0; raddr <= 0; rid_l <= 0; bid_l <= 0; rlen <= 0; rbeat <= 0;
      end else begin
        ar_rnd <= ($urandom_range(0, 1) == 1);
        aw_rnd <= ($urandom_range(0, 1) == 1);
        w_rnd  <= ($urandom_range(0, 3) != 0);
        if (s_arvalid[g] && s_arready[g]) begin
          rbusy <= 1; raddr <= s_araddr[g]; rid_l <= s_arid[g]; rlen <= s_arlen[g]; rbeat <= 0;
        end
        if (!s_rvalid[g] || s_rready[g]) rv_en <= ($urandom_range(0, 3) != 0);
        if (s_rvalid[g] && s_rready[g]) begin
          if (rbeat == rlen) rbusy <= 0;
          else rbeat <= rbeat + 8'd1;
        end
        if (s_awvalid[g] && s_awready[g]) begin awgot <= 1; bid_l <= s_awid[g]; end
        if (s_wvalid[g] && s_wready[g] && s_wlast[g]) wgot <= 1;
        if (s_bvalid[g] && s_bready[g]) begin awgot <= 0; wgot <= 0; end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {logic s; logic [31:0] addr; logic [3:0] id; logic [7:0] len;} sax_t;
  typedef struct packed {logic s; logic [31:0] data; logic [3:0] strb; logic last;} sw_t;
  typedef struct packed {logic [31:0] data; logic [1:0] resp; logic [3:0] id; logic last;} r_t;
  typedef struct packed {logic [1:0] resp; logic [3:0] id;} b_t;
  sax_t exp_ar[$], exp_aw[$];
  sw_t  exp_w[$];
  r_t   exp_r[$];
  b_t   exp_b[$];
  int checks = 0, errors = 0, r_seen = 0, rready_mode = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=transfer required=none", nm);
  endtask

  // Reference decode: plain range arithmetic in 64 bits.
  function automatic int tgt(input logic [31:0] a);
    longint unsigned x;
    x = 64'(a);
    if (x >= 64'(MEM_BASE) && x < 64'(MEM_BASE) + 64'(MEM_SIZE)) return 0;
    if (x >= 64'(DEV_BASE) && x < 64'(DEV_BASE) + 64'(DEV_SIZE)) return 1;
    return 2;
  endfunction

  sax_t mon_a;
  sw_t  mon_w;
  r_t   mon_r;
  b_t   mon_b;
  always @(negedge clk) begin
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        if (s_arvalid[s] && s_arready[s]) begin
          if (exp_ar.size() == 0) unexpected("s_ar");
          else begin
            mon_a = exp_ar.pop_front();
            check("s_ar", {1'(s), s_araddr[s], s_arid[s], s_arlen[s], s_arsize[s], s_arburst[s]},
                  {mon_a.s, mon_a.addr, mon_a.id, mon_a.len, 3'd2, 2'd1});
          end
        end
        if (s_awvalid[s] && s_awready[s]) begin
          if (exp_aw.size() == 0) unexpected("s_aw");
          else begin
            mon_a = exp_aw.pop_front();
            check("s_aw", {1'(s), s_awaddr[s], s_awid[s], s_awlen[s], s_awsize[s], s_awburst[s]},
                  {mon_a.s, mon_a.addr, mon_a.id, mon_a.len, 3'd2, 2'd1});
          end
        end
        if (s_wvalid[s] && s_wready[s]) begin
          if (exp_w.size() == 0) unexpected("s_w");
          else begin
            mon_w = exp_w.pop_front();
            check("s_w", {1'(s), s_wdata[s], s_wstrb[s], s_wlast[s]}, mon_w);
          end
        end
      end
      if (m_rvalid && m_rready) begin
        r_seen++;
        if (exp_r.size() == 0) unexpected("m_r");
        else begin
          mon_r = exp_r.pop_front();
          check("m_r", {m_rdata, m_rresp, m_rid, m_rlast}, mon_r);
        end
      end
      if (m_bvalid && m_bready) begin
        if (exp_b.size() == 0) unexpected("m_b");
        else begin
          mon_b = exp_b.pop_front();
          check("m_b", {m_bresp, m_bid}, mon_b);
        end
      end
    end
  end

  // ---------------- upstream ready drivers ----------------
  initial forever begin
    @(posedge clk); #1;
    case (rready_mode)
      0:       m_rready = 1'b1;
      1:       m_rready = !m_rready;
      default: m_rready = ($urandom_range(0, 2) != 0);
    endcase
    m_bready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- stimulus tasks ----------------
  task automatic send_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    int t;
    bit ok;
    sax_t e;
    r_t r;
    t = tgt(a);
    ok = 0;
    if (t < 2) begin
      e.s = 1'(t); e.addr = a; e.id = id; e.len = len;
      exp_ar.push_back(e);
    end
    for (int b = 0; b <= int'(len); b++) begin
      r.data = (t < 2) ? slv_data(t, a, 8'(b)) : 32'd0;
      r.resp = (t < 2) ? 2'b00 : 2'b11;
      r.id = id;
      r.last = (b == int'(len));
      exp_r.push_back(r);
    end
    m_araddr = a; m_arid = id; m_arlen = len; m_arsize = 3'd2; m_arburst = 2'd1;
    m_arvalid = 1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (m_arready) begin ok = 1; break; end
    end
    check("ar_accept", 64'(ok), 64'd1);
    @(posedge clk); #1;
    m_arvalid = 0; m_araddr = 0; m_arid = 0; m_arlen = 0; m_arsize = 0; m_arburst = 0;
  endtask

  task automatic drive_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    bit ok;
    ok = 0;
    m_awaddr = a; m_awid = id; m_awlen = len; m_awsize = 3'd2; m_awburst = 2'd1;
    m_awvalid = 1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (m_awready) begin ok = 1; break; end
    end
    check("aw_accept", 64'(ok), 64'd1);
    @(posedge clk); #1;
    m_awvalid = 0; m_awaddr = 0; m_awid = 0; m_awlen = 0; m_awsize = 0; m_awburst = 0;
  endtask

  task automatic drive_w(input int t, input logic [7:0] len, input logic [3:0] strb);
    bit ok;
    sw_t e;
    for (int b = 0; b <= int'(len); b++) begin
      ok = 0;
      m_wdata = $urandom; m_wstrb = strb; m_wlast = (b == int'(len)); m_wvalid = 1;
      if (t < 2) begin
        e.s = 1'(t); e.data = m_wdata; e.strb = strb; e.last = m_wlast;
        exp_w.push_back(e);
      end
      for (int n = 0; n < 600; n++) begin
        @(negedge clk);
        if (m_wready) begin ok = 1; break; end
      end
      check("w_accept", 64'(ok), 64'd1);
      @(posedge clk); #1;
    end
    m_wvalid = 0; m_wdata = 0; m_wstrb = 0; m_wlast = 0;
  endtask

  // w_lead: W beat presented this many cycles before AW; it must be held off.
  task automatic do_write(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                          input logic [3:0] strb, input int w_lead);
    int t;
    sax_t e;
    b_t b;
    t = tgt(a);
    if (t < 2) begin
      e.s = 1'(t); e.addr = a; e.id = id; e.len = len;
      exp_aw.push_back(e);
    end
    b.resp = (t == 0) ? 2'b00 : (t == 1) ? 2'b01 : 2'b11;
    b.id = id;
    exp_b.push_back(b);
    fork
      begin
        for (int i = 0; i < w_lead; i++) begin
          @(negedge clk);
          check("w_held", 64'(m_wready), 64'd0);
          @(posedge clk); #1;
        end
        drive_aw(a, id, len);
      end
      drive_w(t, len, strb);
    join
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_ar.size() + exp_r.size() + exp_aw.size() + exp_w.size() + exp_b.size()) != 0
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(n < budget), 64'd1);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] handshakes();
    return {m_arready, m_rvalid, m_awready, m_wready, m_bvalid,
            s_arvalid[0], s_arvalid[1], s_rready[0], s_rready[1], s_awvalid[0], s_awvalid[1],
            s_wvalid[0], s_wvalid[1], s_bready[0], s_bready[1]};
  endfunction

  function automatic logic payload_any();
    logic p;
    p = |{m_rdata, m_rresp, m_rid, m_rlast, m_bresp, m_bid};
    for (int s = 0; s < 2; s++)
      p |= |{s_araddr[s], s_arid[s], s_arlen[s], s_arsize[s], s_arburst[s], s_awaddr[s],
             s_awid[s], s_awlen[s], s_awsize[s], s_awburst[s], s_wdata[s], s_wstrb[s], s_wlast[s]};
    return p;
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0: return MEM_BASE + ($urandom % MEM_SIZE & 32'hffff_fffc);
      1: return MEM_BASE;
      2: return MEM_BASE + MEM_SIZE - 32'd4;
      3: return MEM_BASE + MEM_SIZE;
      4: return DEV_BASE + ($urandom % DEV_SIZE & 32'hffff_fffc);
      5: return DEV_BASE + DEV_SIZE - 32'd4;
      6: return DEV_BASE - 32'd4;
      default: return $urandom & 32'hffff_fffc;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int start;
    #12;
    check("reset_handshakes", 64'(handshakes()), 64'd0);
    check("reset_payload", 64'(payload_any()), 64'd0);
    #11 rst = 0;
    @(posedge clk); #1;

    // memory read: AR reaches s0 one cycle after m_arvalid
    rready_mode = 0;
    fork
      send_ar(32'h8000_0010, 4'd2, 8'd0);
      begin
        @(negedge clk); check("ar_lat_idle", 64'(s_arvalid[0]), 64'd0);
        @(negedge clk); check("ar_lat_fwd", 64'(s_arvalid[0]), 64'd1);
      end
    join
    drain(200);

    // UART read goes to s1
    send_ar(32'ha000_03f8, 4'd6, 8'd0);
    drain(200);

    // decode-error read, 4 beats, then with rready toggling
    send_ar(32'h0000_1000, 4'd5, 8'd3);
    drain(200);
    rready_mode = 1;
    send_ar(32'h0000_1000, 4'd5, 8'd3);
    drain(200);
    rready_mode = 0;

    // W presented 2 cycles before AW
    do_write(32'h8000_0100, 4'd4, 8'd0, 4'b0011, 2);
    drain(200);

    // concurrent read to s1 and write to s0
    fork
      send_ar(32'ha000_0010, 4'd9, 8'd1);
      do_write(32'h8000_0200, 4'd3, 8'd1, 4'hf, 0);
    join
    drain(300);

    // decode-error write burst
    do_write(32'h0000_1000, 4'd12, 8'd3, 4'hf, 0);
    drain(200);

    // 256-beat decode-error read
    send_ar(32'h1000_0000, 4'd1, 8'd255);
    drain(600);

    // reset during beat 2 of a 4-beat memory burst
    send_ar(MEM_BASE + 32'h40, 4'd7, 8'd3);
    start = r_seen;
    for (int n = 0; n < 200 && r_seen == start; n++) @(posedge clk);
    check("beat1_seen", 64'(r_seen - start), 64'd1);
    #2 rst = 1;
    #1;
    check("midrst_handshakes", 64'(handshakes()), 64'd0);
    check("midrst_payload", 64'(payload_any()), 64'd0);
    exp_ar.delete(); exp_r.delete(); exp_aw.delete(); exp_w.delete(); exp_b.delete();
    @(posedge clk); @(posedge clk); #3 rst = 0;
    @(posedge clk); #1;
    send_ar(MEM_BASE + 32'h80, 4'd8, 8'd1);
    drain(200);

    // randomised mix of concurrent reads and writes
    rready_mode = 2;
    fork
      for (int i = 0; i < 25; i++)
        send_ar(rand_addr(), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 3)));
      for (int i = 0; i < 25; i++)
        do_write(rand_addr(), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 3)),
                 4'($urandom_range(1, 15)), $urandom_range(0, 2));
    join
    drain(2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
